axis_port_stats: RTL and testbench

//  Parametrised successor to the single free-running-counter TX block: a full-rate AXI4-Stream

---
 rtl/axis_port_stats_if.sv | 15 +
 rtl/axis_port_stats.sv | 213 +++++++++++++++++++++
 tb/tb_axis_port_stats.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_port_stats_if.sv
// AXI4-Stream bundle used for both the input and output sides of axis_port_stats.
interface axis_port_stats_if #(
  parameter int DW = 64,
  parameter int UW = 128
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_port_stats.sv
// AXI4-Stream register slice with per-source-port packet/byte counters readable over IPIF.
// Define STATS_SATURATE_EN to make all counters stick at all-ones instead of wrapping.
module axis_port_stats #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_PORTS        = 4,
  parameter int C_CNTR_WIDTH       = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
  input  logic                            Bus2IP_CS,
  input  logic                            Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
  output logic                            IP2Bus_RdAck,
  output logic                            IP2Bus_WrAck,
  output logic                            IP2Bus_Error,
  axis_port_stats_if.slave                s_axis,
  axis_port_stats_if.master               m_axis
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int NP = C_NUM_PORTS;
  localparam int CW = C_CNTR_WIDTH;

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic {BUS_IDLE, BUS_WAIT} bus_st_e;

  function automatic cnt_t add_c(input cnt_t a, input cnt_t b);
`ifdef STATS_SATURATE_EN
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    add_c = s[CW] ? '1 : s[CW-1:0];
`else
    add_c = a + b;
`endif
  endfunction

  function automatic cnt_t popcnt(input logic [SW-1:0] v);
    popcnt = '0;
    for (int i = 0; i < SW; i++) popcnt = popcnt + cnt_t'(v[i]);
  endfunction

  // stream slice
  logic                         m_vld_q, m_vld_d, m_last_q, m_last_d;
  logic [C_AXIS_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [SW-1:0]                m_strb_q, m_strb_d;
  logic [UW-1:0]                m_user_q, m_user_d;
  logic                         s_ready, accept;

  assign s_ready       = ~m_vld_q | m_axis.tready;
  assign accept        = s_axis.tvalid & s_ready;
  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tstrb  = m_strb_q;
  assign m_axis.tuser  = m_user_q;
  assign m_axis.tlast  = m_last_q;

  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_strb_d = m_strb_q;
    m_user_d = m_user_q;
    m_last_d = m_last_q;
    if (m_axis.tready) m_vld_d = 1'b0;
    if (accept) begin
      m_vld_d  = 1'b1;
      m_data_d = s_axis.tdata;
      m_strb_d = s_axis.tstrb;
      m_user_d = s_axis.tuser;
      m_last_d = s_axis.tlast;
    end
  end

  // counters
  logic [1:0]            ctrl_q, ctrl_d;
  cnt_t                  acc_q, acc_d, cyc_q, cyc_d, unk_q, unk_d;
  logic [NP-1:0][CW-1:0] pkt_q, pkt_d, byt_q, byt_d;
  logic [NP-1:0]         sel;
  logic                  onehot, clear, freeze;
  cnt_t                  pop;

  assign clear  = ctrl_q[0];
  assign freeze = ctrl_q[1];
  assign pop    = popcnt(s_axis.tstrb);
  assign sel    = s_axis.tuser[16 +: NP];
  assign onehot = (sel != '0) && ((sel & (sel - NP'(1))) == '0);

  always_comb begin
    acc_d = acc_q;
    cyc_d = freeze ? cyc_q : add_c(cyc_q, cnt_t'(1));
    unk_d = unk_q;
    pkt_d = pkt_q;
    byt_d = byt_q;
    if (accept) acc_d = s_axis.tlast ? '0 : add_c(acc_q, pop);
    if (accept && s_axis.tlast && !freeze) begin
      if (onehot) begin
        for (int i = 0; i < NP; i++) begin
          if (sel[i]) begin
            pkt_d[i] = add_c(pkt_q[i], cnt_t'(1));
            byt_d[i] = add_c(byt_q[i], add_c(acc_q, pop));
          end
        end
      end else begin
        unk_d = add_c(unk_q, cnt_t'(1));
      end
    end
    // clear wins over every increment, including the one on this edge
    if (clear) begin
      acc_d = '0;
      cyc_d = '0;
      unk_d = '0;
      pkt_d = '0;
      byt_d = '0;
    end
  end

  // IPIF register access
  bus_st_e       st_q, st_d;
  logic [5:0]    idx;
  logic [DW-1:0] rd_mux, rdata_q, rdata_d;
  logic          mapped, rdack_q, rdack_d, wrack_q, wrack_d, err_q, err_d;
  logic          unused_bus;

  assign idx          = Bus2IP_Addr[7:2];
  assign IP2Bus_Data  = rdata_q;
  assign IP2Bus_RdAck = rdack_q;
  assign IP2Bus_WrAck = wrack_q;
  assign IP2Bus_Error = err_q;
  assign unused_bus   = ^{Bus2IP_BE, Bus2IP_Addr[C_S_AXI_ADDR_WIDTH-1:8],
                          Bus2IP_Addr[1:0], Bus2IP_Data[DW-1:2]};

  always_comb begin
    rd_mux = '0;
    mapped = 1'b0;
    case (idx)
      6'd0: begin rd_mux = DW'(ctrl_q); mapped = 1'b1; end
      6'd1: begin rd_mux = DW'(cyc_q);  mapped = 1'b1; end
      6'd2: begin rd_mux = DW'(unk_q);  mapped = 1'b1; end
      default: ;
    endcase
    for (int i = 0; i < NP; i++) begin
      if (idx == 6'(4 + 2 * i)) begin rd_mux = DW'(pkt_q[i]); mapped = 1'b1; end
      if (idx == 6'(5 + 2 * i)) begin rd_mux = DW'(byt_q[i]); mapped = 1'b1; end
    end
  end

  // one ack per CS assertion; re-armed only after CS is seen low
  always_comb begin
    st_d    = st_q;
    ctrl_d  = ctrl_q;
    rdata_d = '0;
    rdack_d = 1'b0;
    wrack_d = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      BUS_IDLE: if (Bus2IP_CS) begin
        st_d    = BUS_WAIT;
        rdack_d = Bus2IP_RNW;
        wrack_d = ~Bus2IP_RNW;
        err_d   = ~mapped;
        if (Bus2IP_RNW && mapped) rdata_d = rd_mux;
        if (!Bus2IP_RNW && idx == 6'd0) ctrl_d = Bus2IP_Data[1:0];
      end
      BUS_WAIT: if (!Bus2IP_CS) st_d = BUS_IDLE;
      default:  st_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_strb_q <= '0;
      m_user_q <= '0;
      m_last_q <= 1'b0;
      ctrl_q   <= '0;
      acc_q    <= '0;
      cyc_q    <= '0;
      unk_q    <= '0;
      pkt_q    <= '0;
      byt_q    <= '0;
      st_q     <= BUS_IDLE;
      rdata_q  <= '0;
      rdack_q  <= 1'b0;
      wrack_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      m_strb_q <= m_strb_d;
      m_user_q <= m_user_d;
      m_last_q <= m_last_d;
      ctrl_q   <= ctrl_d;
      acc_q    <= acc_d;
      cyc_q    <= cyc_d;
      unk_q    <= unk_d;
      pkt_q    <= pkt_d;
      byt_q    <= byt_d;
      st_q     <= st_d;
      rdata_q  <= rdata_d;
      rdack_q  <= rdack_d;
      wrack_q  <= wrack_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_axis_port_stats.sv
// Directed + randomized bench for axis_port_stats; counters run 8 bits wide so wrap/saturate is reachable.
module tb_axis_port_stats;
  localparam int NP = 4;
  localparam int CW = 8;
  localparam longint CMAX = (64'd1 << CW) - 1;

  typedef logic [200:0] beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr, bdata, rdata;
  logic [3:0]  be;
  logic        cs, rnw, rdack, wrack, err;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  bit          tgl = 1'b0;

  axis_port_stats_if #(.DW(64), .UW(128)) s_if ();
  axis_port_stats_if #(.DW(64), .UW(128)) m_if ();

  axis_port_stats #(.C_NUM_PORTS(NP), .C_CNTR_WIDTH(CW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .Bus2IP_Addr(addr), .Bus2IP_CS(cs), .Bus2IP_RNW(rnw), .Bus2IP_Data(bdata), .Bus2IP_BE(be),
    .IP2Bus_Data(rdata), .IP2Bus_RdAck(rdack), .IP2Bus_WrAck(wrack), .IP2Bus_Error(err),
    .s_axis(s_if), .m_axis(m_if)
  );

  // reference model: true (unbounded) totals since last clear, folded at compare time
  beat_t      exp_q[$];
  logic [7:0] strb_q[$];
  longint     m_pkt[NP], m_byt[NP], m_unk, m_acc;
  bit         m_freeze = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fold(input longint v);
`ifdef STATS_SATURATE_EN
    return (v > CMAX) ? 256'(CMAX) : 256'(v);
`else
    return 256'(v % (CMAX + 1));
`endif
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < NP; i++) begin m_pkt[i] = 0; m_byt[i] = 0; end
    m_unk = 0;
    m_acc = 0;
  endfunction

  function automatic void model_beat(input logic [7:0] s, input logic [7:0] sel, input logic l);
    m_acc += $countones(s);
    if (l) begin
      if (!m_freeze) begin
        if ($countones(sel[NP-1:0]) == 1) begin
          for (int i = 0; i < NP; i++)
            if (sel[i]) begin m_pkt[i]++; m_byt[i] += m_acc; end
        end else m_unk++;
      end
      m_acc = 0;
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    m_if.tready = tgl ? ~m_if.tready : 1'b1;
  end

  // output monitor: order/content vs queue, stability under back-pressure
  beat_t       mon_cur;
  logic [201:0] held;
  bit          was_stall = 1'b0;
  always @(negedge clk) begin
    mon_cur = {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata};
    if (!rst_n) was_stall = 1'b0;
    else begin
      if (was_stall) check("m_stable", 256'({m_if.tvalid, mon_cur}), 256'(held));
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) check("m_extra_beat", 256'(exp_q.size()), 256'(1));
        else check("m_beat", 256'(mon_cur), 256'(exp_q.pop_front()));
      end
      was_stall = m_if.tvalid && !m_if.tready;
      held = {1'b1, mon_cur};
    end
  end

  // caller sits 1 time unit after a rising edge; returns likewise after the accepting edge
  task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic [127:0] u, input logic l);
    int n = 0;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tstrb = s; s_if.tuser = u; s_if.tlast = l;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      if (++n > 50) begin check("s_tready_timeout", 256'(s_if.tready), 256'(1)); break; end
    end
    exp_q.push_back({l, u, s, d});
    model_beat(s, u[23:16], l);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] sel, input int nb);
    logic [127:0] u;
    logic [7:0]   s;
    for (int b = 0; b < nb; b++) begin
      u = {$urandom, $urandom, $urandom, $urandom};
      u[23:16] = sel;
      s = (strb_q.size() != 0) ? strb_q.pop_front() : 8'($urandom);
      send_beat({$urandom, $urandom}, s, u, b == nb - 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("drain", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic bus(input logic r, input int idx, input logic [31:0] wd,
                     output logic [31:0] d, output logic e);
    int n = 0;
    addr = 32'(idx) << 2; rnw = r; bdata = wd; cs = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!(rdack || wrack) && n < 10);
    check($sformatf("ack_kind_w%0d", idx), 256'({rdack, wrack}), 256'(r ? 2'b10 : 2'b01));
    d = rdata; e = err;
    cs = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", 256'({rdack, wrack}), 256'(0));
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    logic e;
    bus(1'b1, idx, 32'd0, d, e);
    check($sformatf("rd_err_w%0d", idx), 256'(e), 256'(0));
  endtask

  task automatic wr(input int idx, input logic [31:0] v, input logic exp_err);
    logic [31:0] d;
    logic e;
    bus(1'b0, idx, v, d, e);
    check($sformatf("wr_err_w%0d", idx), 256'(e), 256'(exp_err));
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d;
    rd(2, d); check({tag, "_unk"}, 256'(d), fold(m_unk));
    for (int i = 0; i < NP; i++) begin
      rd(4 + 2 * i, d); check($sformatf("%s_pkt%0d", tag, i), 256'(d), fold(m_pkt[i]));
      rd(5 + 2 * i, d); check($sformatf("%s_byt%0d", tag, i), 256'(d), fold(m_byt[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, c1, c2;
    logic        e;
    int          c0, acks;
    logic [7:0]  sel;

    cs = 1'b0; rnw = 1'b1; addr = '0; bdata = '0; be = '1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 256'(m_if.tvalid), 256'(0));
    check("rst_m_data",  256'({m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata}), 256'(0));
    check("rst_ipif",    256'({rdata, rdack, wrack, err}), 256'(0));
    check("rst_s_ready", 256'(s_if.tready), 256'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("rst");

    // 3-beat packet to port 2, full-rate with 1-cycle latency
    strb_q = '{8'hFF, 8'hFF, 8'h0F};
    c0 = cyc;
    send_pkt(8'h04, 3);
    check("t1_rate", 256'(cyc - c0), 256'(3));
    check("t1_last_out", 256'({m_if.tvalid, m_if.tlast, m_if.tstrb}), 256'({1'b1, 1'b1, 8'h0F}));
    drain();
    rd(8, d); check("t1_pkt2", 256'(d), 256'(1));
    rd(9, d); check("t1_byt2", 256'(d), 256'(20));

    // 64 back-to-back single-beat packets under toggling back-pressure
    tgl = 1'b1;
    for (int k = 0; k < 64; k++) send_pkt(8'h01, 1);
    drain();
    tgl = 1'b0;
    rd(4, d); check("t2_pkt0", 256'(d), 256'(64));
    check_all("t2");

    // zero/multi-hot select
    send_pkt(8'h03, 2);
    rd(2, d); check("t3_unk", 256'(d), 256'(1));
    check_all("t3");

    // randomized packets
    for (int k = 0; k < 24; k++) begin
      tgl = $urandom_range(0, 1);
      sel = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, NP - 1));
      send_pkt(sel, $urandom_range(1, 4));
    end
    tgl = 1'b0;
    drain();
    check_all("rand");

    // clear issued on the same edge as a TLAST beat
    fork
      send_pkt(8'h02, 1);
      wr(0, 32'd1, 1'b0);
    join
    drain();
    model_zero();
    rd(0, d); check("clr_ctrl", 256'(d), 256'(1));
    rd(1, d); check("clr_cyc",  256'(d), 256'(0));
    check_all("clr");
    wr(0, 32'd0, 1'b0);
    rd(1, c1);
    rd(1, c2);
    check("cyc_incr", 256'(c2 > c1), 256'(1));

    // freeze: counters hold, accumulator keeps tracking a packet that spans the unfreeze
    wr(0, 32'd2, 1'b0);
    m_freeze = 1'b1;
    rd(1, c1);
    for (int k = 0; k < 5; k++) send_pkt(8'h02, $urandom_range(1, 3));
    rd(1, c2);
    check("cyc_frozen", 256'(c2), 256'(c1));
    check_all("frz");
    send_beat(64'h1, 8'hFF, 128'h0002_0000, 1'b0);
    wr(0, 32'd0, 1'b0);
    m_freeze = 1'b0;
    send_beat(64'h2, 8'h01, 128'h0002_0000, 1'b1);
    drain();
    rd(6, d); check("unfrz_pkt1", 256'(d), 256'(1));
    rd(7, d); check("unfrz_byt1", 256'(d), 256'(9));
    check_all("unfrz");

    // unmapped and read-only accesses
    bus(1'b1, 3, 32'd0, d, e);
    check("unmap3", 256'({e, d}), 256'({1'b1, 32'd0}));
    bus(1'b1, 63, 32'd0, d, e);
    check("unmap63", 256'({e, d}), 256'({1'b1, 32'd0}));
    wr(5, 32'hFF, 1'b0);
    wr(40, 32'h3, 1'b1);
    rd(0, d); check("ctrl_after_wr", 256'(d), 256'(0));
    check_all("ro");

    // CS held high yields exactly one ack
    addr = 32'd2 << 2; rnw = 1'b1; cs = 1'b1; acks = 0;
    repeat (5) begin @(posedge clk); #1; acks += int'(rdack); end
    check("cs_hold_acks", 256'(acks), 256'(1));
    cs = 1'b0;
    @(posedge clk); #1;

    // overflow: 256 packets of 1 byte on port 0 after a clear
    wr(0, 32'd1, 1'b0);
    wr(0, 32'd0, 1'b0);
    model_zero();
    for (int k = 0; k < 256; k++) begin strb_q.push_back(8'h01); send_pkt(8'h01, 1); end
    drain();
`ifdef STATS_SATURATE_EN
    rd(4, d); check("ovf_pkt0", 256'(d), 256'(CMAX));
`else
    rd(4, d); check("ovf_pkt0", 256'(d), 256'(0));
`endif
    check_all("ovf");

    // reset in the middle of a packet
    send_beat(64'hA, 8'hFF, 128'h0008_0000, 1'b0);
    send_beat(64'hB, 8'hFF, 128'h0008_0000, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_valid", 256'(m_if.tvalid), 256'(0));
    exp_q.delete();
    model_zero();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    strb_q = '{8'hFF};
    send_pkt(8'h08, 1);
    drain();
    rd(11, d); check("rst_mid_byt3", 256'(d), 256'(8));
    check_all("rstmid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
